// File: rtl/flow_ctrl.sv
// flow_ctrl: pipeline stall/flush/redirect controller for load-use,
// EX jumps and data-memory wait states with timeout and perf counters.
module flow_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_raddr_i,
  input  logic [4:0]  id_rs2_raddr_i,
  input  logic        id_rs1_re_i,
  input  logic        id_rs2_re_i,
  input  logic [4:0]  idex_reg_waddr_i,
  input  logic        idex_reg_we_i,
  input  logic        idex_mtype_i,
  input  logic        idex_mem_rw_i,
  input  logic        ex_jump_flag_i,
  input  logic [31:0] ex_jump_pc_i,
  input  logic        exmem_mem_req_i,
  input  logic        dmem_ready_i,
  output logic        fc_stall_pc_o,
  output logic        fc_stall_ifid_o,
  output logic        fc_stall_idex_o,
  output logic        fc_stall_exmem_o,
  output logic        fc_flush_ifid_o,
  output logic        fc_flush_idex_o,
  output logic        fc_flush_exmem_o,
  output logic        fc_jump_flag_o,
  output logic [31:0] fc_jump_pc_o,
  output logic        fc_mem_err_o,
  output logic [31:0] fc_stall_cnt_o,
  output logic [31:0] fc_jump_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_nxt;
  logic [7:0]  w_wait_inc;
  logic        w_memwait;
  logic        w_loaduse;
  logic        w_rs1_hit;
  logic        w_rs2_hit;

  assign w_wait_inc = r_wait_cnt + 8'd1;

  assign w_memwait =
    ((r_state == RUN) & exmem_mem_req_i & ~dmem_ready_i) |
    ((r_state == MEM_WAIT) & ~dmem_ready_i);

  assign w_rs1_hit = id_rs1_re_i &
    (id_rs1_raddr_i == idex_reg_waddr_i);
  assign w_rs2_hit = id_rs2_re_i &
    (id_rs2_raddr_i == idex_reg_waddr_i);

  assign w_loaduse = idex_mtype_i & ~idex_mem_rw_i &
    idex_reg_we_i & (idex_reg_waddr_i != 5'd0) &
    (w_rs1_hit | w_rs2_hit);

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    unique case (r_state)
      RUN: begin
        if (exmem_mem_req_i & ~dmem_ready_i) begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_i) begin
          w_state_nxt = RUN;
          w_wait_nxt  = 8'd0;
        end else begin
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc == TMO)
            w_state_nxt = MEM_ERR;
        end
      end
      MEM_ERR: begin
        w_state_nxt = RUN;
        w_wait_nxt  = 8'd0;
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = 8'd0;
      end
    endcase
  end

  // Strict priority: timeout drop, memory wait, jump, load-use.
  always_comb begin
    fc_stall_pc_o    = 1'b0;
    fc_stall_ifid_o  = 1'b0;
    fc_stall_idex_o  = 1'b0;
    fc_stall_exmem_o = 1'b0;
    fc_flush_ifid_o  = 1'b0;
    fc_flush_idex_o  = 1'b0;
    fc_flush_exmem_o = 1'b0;
    fc_jump_flag_o   = 1'b0;
    fc_mem_err_o     = 1'b0;
    if (r_state == MEM_ERR) begin
      fc_stall_pc_o    = 1'b1;
      fc_stall_ifid_o  = 1'b1;
      fc_stall_idex_o  = 1'b1;
      fc_flush_exmem_o = 1'b1;
      fc_mem_err_o     = 1'b1;
    end else if (w_memwait) begin
      fc_stall_pc_o    = 1'b1;
      fc_stall_ifid_o  = 1'b1;
      fc_stall_idex_o  = 1'b1;
      fc_stall_exmem_o = 1'b1;
    end else if (ex_jump_flag_i) begin
      fc_jump_flag_o  = 1'b1;
      fc_flush_ifid_o = 1'b1;
      fc_flush_idex_o = 1'b1;
    end else if (w_loaduse) begin
      fc_stall_pc_o   = 1'b1;
      fc_stall_ifid_o = 1'b1;
      fc_flush_idex_o = 1'b1;
    end
  end

  assign fc_jump_pc_o = fc_jump_flag_o ? ex_jump_pc_i : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_stall_cnt_o <= 32'd0;
      fc_jump_cnt_o  <= 32'd0;
    end else begin
      if (fc_stall_pc_o && (fc_stall_cnt_o != 32'hFFFF_FFFF))
        fc_stall_cnt_o <= fc_stall_cnt_o + 32'd1;
      if (fc_jump_flag_o && (fc_jump_cnt_o != 32'hFFFF_FFFF))
        fc_jump_cnt_o <= fc_jump_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_flow_ctrl.sv
// tb_flow_ctrl: directed vectors for flow_ctrl, MEM_TIMEOUT=4.
// Control outputs packed {spc,sif,sid,sex,fif,fid,fex,jmp,err}.
module tb_flow_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, waddr;
  logic        rs1_re, rs2_re, we, mtype, rw;
  logic        jf;
  logic [31:0] jpc;
  logic        req, rdy;
  logic        spc, sif, sid, sex, fif, fid, fex, jmp, err;
  logic [31:0] jpc_o, scnt, jcnt;

  int checks = 0;
  int failures = 0;

  localparam logic [8:0] IDLE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110001000;
  localparam logic [8:0] JMP  = 9'b000011010;
  localparam logic [8:0] MW   = 9'b111100000;
  localparam logic [8:0] ERR  = 9'b111000101;

  flow_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_rs1_raddr_i   (rs1),
    .id_rs2_raddr_i   (rs2),
    .id_rs1_re_i      (rs1_re),
    .id_rs2_re_i      (rs2_re),
    .idex_reg_waddr_i (waddr),
    .idex_reg_we_i    (we),
    .idex_mtype_i     (mtype),
    .idex_mem_rw_i    (rw),
    .ex_jump_flag_i   (jf),
    .ex_jump_pc_i     (jpc),
    .exmem_mem_req_i  (req),
    .dmem_ready_i     (rdy),
    .fc_stall_pc_o    (spc),
    .fc_stall_ifid_o  (sif),
    .fc_stall_idex_o  (sid),
    .fc_stall_exmem_o (sex),
    .fc_flush_ifid_o  (fif),
    .fc_flush_idex_o  (fid),
    .fc_flush_exmem_o (fex),
    .fc_jump_flag_o   (jmp),
    .fc_jump_pc_o     (jpc_o),
    .fc_mem_err_o     (err),
    .fc_stall_cnt_o   (scnt),
    .fc_jump_cnt_o    (jcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ctl();
    return {23'd0, spc, sif, sid, sex, fif, fid, fex, jmp, err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rs1_re = 1'b0; rs2_re = 1'b0;
    waddr = 5'd0; we = 1'b0; mtype = 1'b0; rw = 1'b0;
    jf = 1'b0; jpc = 32'd0; req = 1'b0; rdy = 1'b0;
  endtask

  task automatic load5();
    mtype = 1'b1; rw = 1'b0; we = 1'b1; waddr = 5'd5;
    rs1 = 5'd5; rs1_re = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    tick();
    #1;
    chk("rst_ctl", ctl(), {23'd0, IDLE});
    chk("rst_scnt", scnt, 32'd0);
    chk("rst_jcnt", jcnt, 32'd0);
    chk("rst_jpc", jpc_o, 32'd0);

    // load-use on rs1, then load has moved on
    tick(); load5(); #1;
    chk("lu_hit", ctl(), {23'd0, LU});
    tick(); idle(); #1;
    chk("lu_clear", ctl(), {23'd0, IDLE});
    load5(); waddr = 5'd0; rs1 = 5'd0; #1;
    chk("lu_x0", ctl(), {23'd0, IDLE});
    load5(); rs1_re = 1'b0; rs2 = 5'd5; rs2_re = 1'b1; #1;
    chk("lu_rs2", ctl(), {23'd0, LU});
    rs2_re = 1'b0; #1;
    chk("lu_nore", ctl(), {23'd0, IDLE});
    rs1_re = 1'b1; rw = 1'b1; #1;
    chk("lu_store", ctl(), {23'd0, IDLE});
    idle();
    tick(); #1;
    chk("lu_scnt", scnt, 32'd1);

    // jump wins over concurrent load-use
    load5(); jf = 1'b1; jpc = 32'h8000_0040; #1;
    chk("jmp_ctl", ctl(), {23'd0, JMP});
    chk("jmp_pc", jpc_o, 32'h8000_0040);
    tick(); idle(); #1;
    chk("jmp_cnt", jcnt, 32'd1);
    chk("jmp_pc0", jpc_o, 32'd0);
    chk("jmp_scnt", scnt, 32'd1);

    // memory wait: ready on 4th cycle
    req = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("mw_%0d", i), ctl(), {23'd0, MW});
      tick();
    end
    rdy = 1'b1; #1;
    chk("mw_rdy", ctl(), {23'd0, IDLE});
    tick(); idle(); #1;
    chk("mw_run", ctl(), {23'd0, IDLE});
    chk("mw_scnt", scnt, 32'd4);

    // timeout: 4 stall cycles, one error cycle, then run
    req = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("to_%0d", i), ctl(), {23'd0, MW});
      tick();
    end
    rdy = 1'b1; #1;
    chk("to_err", ctl(), {23'd0, ERR});
    tick(); idle(); #1;
    chk("to_run", ctl(), {23'd0, IDLE});
    chk("to_scnt", scnt, 32'd9);

    // jump held during wait, released with ready
    req = 1'b1; rdy = 1'b0; jf = 1'b1; jpc = 32'h0000_0100; #1;
    chk("jw_stall", ctl(), {23'd0, MW});
    chk("jw_pc0", jpc_o, 32'd0);
    tick(); rdy = 1'b1; #1;
    chk("jw_go", ctl(), {23'd0, JMP});
    chk("jw_pc", jpc_o, 32'h0000_0100);
    tick(); idle(); #1;
    chk("jw_scnt", scnt, 32'd10);
    chk("jw_jcnt", jcnt, 32'd2);

    // async reset after two wait cycles
    req = 1'b1; rdy = 1'b0;
    tick(); tick();
    #1 chk("rs_pre", ctl(), {23'd0, MW});
    #1 rst_n = 1'b0; req = 1'b0; #1;
    chk("rs_ctl", ctl(), {23'd0, IDLE});
    chk("rs_scnt", scnt, 32'd0);
    chk("rs_jcnt", jcnt, 32'd0);
    tick();
    rst_n = 1'b1; req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("rs_mw_%0d", i), ctl(), {23'd0, MW});
      tick();
    end
    #1 chk("rs_err", ctl(), {23'd0, ERR});
    tick(); idle(); #1;
    chk("rs_run", ctl(), {23'd0, IDLE});
    chk("rs_scnt2", scnt, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
